peripheral_axi3_slave_mem: RTL

//  AXI3 memory-backed responder: the slave end of the AXI3 channel bundle on aclk/aresetn.

---
 rtl/peripheral_axi3_pkg.sv | 20 ++
 rtl/peripheral_axi3_ram_1w1r.sv | 33 +++
 rtl/peripheral_axi3_slave_mem.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_axi3_pkg.sv
// Shared constants and state types for the AXI3 memory-backed slave.
package peripheral_axi3_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] addr_step(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/peripheral_axi3_ram_1w1r.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module peripheral_axi3_ram_1w1r #(
  parameter int WORDS = 1024,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q;

  // A same-cycle read of the word being written returns the old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && wstrb[b]) begin
        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/peripheral_axi3_slave_mem.sv
// AXI3 slave backed by on-chip RAM; independent write and read burst engines.
module peripheral_axi3_slave_mem
  import peripheral_axi3_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int ID_W      = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awadr,
  input  logic [3:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wrdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [3:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int IDX_W = AW - 2;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  // Lock, cache and protection attributes have no effect on this target.
  logic unused_attr;
  assign unused_attr = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  wr_state_t       wr_state_q, wr_state_d;
  logic [ID_W-1:0] w_id_q, w_id_d;
  logic [31:0]     w_addr_q, w_addr_d;
  logic [3:0]      w_len_q, w_len_d;
  logic [2:0]      w_size_q, w_size_d;
  logic            w_fixed_q, w_fixed_d;
  logic [3:0]      w_cnt_q, w_cnt_d;
  logic            w_err_q, w_err_d;

  rd_state_t       rd_state_q, rd_state_d;
  logic [ID_W-1:0] r_id_q, r_id_d;
  logic [31:0]     r_addr_q, r_addr_d;
  logic [3:0]      r_len_q, r_len_d;
  logic [2:0]      r_size_q, r_size_d;
  logic [3:0]      r_cnt_q, r_cnt_d;
  logic            r_oor_q, r_oor_d;

  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_raddr;
  logic [31:0]      ram_rdata;
  logic             w_in_range, w_beat_last, r_beat_last;
  logic [31:0]      r_next_addr;

  assign w_in_range  = (w_addr_q < MEM_LIMIT);
  assign w_beat_last = (w_cnt_q == w_len_q);
  assign r_beat_last = (r_cnt_q == r_len_q);
  assign r_next_addr = r_addr_q + addr_step(r_size_q);

  peripheral_axi3_ram_1w1r #(.WORDS(MEM_BYTES / 4)) u_ram (
    .clk   (aclk),
    .we    (ram_we),
    .waddr (w_addr_q[AW-1:2]),
    .wdata (wrdata),
    .wstrb (wstrb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    w_id_d     = w_id_q;
    w_addr_d   = w_addr_q;
    w_len_d    = w_len_q;
    w_size_d   = w_size_q;
    w_fixed_d  = w_fixed_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    ram_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (awvalid) begin
          w_id_d     = awid;
          w_addr_d   = awadr;
          w_len_d    = awlen;
          w_size_d   = awsize;
          w_fixed_d  = (awburst == BURST_FIXED);
          w_cnt_d    = 4'd0;
          // WRAP and the reserved encoding step like INCR but always fail.
          w_err_d    = (awsize > 3'd2) || awburst[1];
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          ram_we   = w_in_range;
          w_err_d  = w_err_q || !w_in_range || (wid != w_id_q) || (wlast != w_beat_last);
          w_cnt_d  = w_cnt_q + 4'd1;
          w_addr_d = w_fixed_q ? w_addr_q : (w_addr_q + addr_step(w_size_q));
          if (w_beat_last) begin
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    r_id_d     = r_id_q;
    r_addr_d   = r_addr_q;
    r_len_d    = r_len_q;
    r_size_d   = r_size_q;
    r_cnt_d    = r_cnt_q;
    r_oor_d    = r_oor_q;
    ram_re     = 1'b0;
    ram_raddr  = araddr[AW-1:2];
    case (rd_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_id_d     = arid;
          r_addr_d   = araddr;
          r_len_d    = arlen;
          r_size_d   = arsize;
          r_cnt_d    = 4'd0;
          r_oor_d    = (araddr >= MEM_LIMIT);
          ram_re     = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_beat_last) begin
            rd_state_d = R_IDLE;
          end else begin
            // Fetch the next beat now so it is presented right after this handshake.
            ram_re    = 1'b1;
            ram_raddr = r_next_addr[AW-1:2];
            r_addr_d  = r_next_addr;
            r_oor_d   = (r_next_addr >= MEM_LIMIT);
            r_cnt_d   = r_cnt_q + 4'd1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_size_q   <= '0;
      w_fixed_q  <= 1'b0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      rd_state_q <= R_IDLE;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_size_q   <= '0;
      r_cnt_q    <= '0;
      r_oor_q    <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      w_id_q     <= w_id_d;
      w_addr_q   <= w_addr_d;
      w_len_q    <= w_len_d;
      w_size_q   <= w_size_d;
      w_fixed_q  <= w_fixed_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      rd_state_q <= rd_state_d;
      r_id_q     <= r_id_d;
      r_addr_q   <= r_addr_d;
      r_len_q    <= r_len_d;
      r_size_q   <= r_size_d;
      r_cnt_q    <= r_cnt_d;
      r_oor_q    <= r_oor_d;
    end
  end

  assign awready = (wr_state_q == W_IDLE);
  assign wready  = (wr_state_q == W_DATA);
  assign bvalid  = (wr_state_q == W_RESP);
  assign bresp   = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign bid     = w_id_q;

  assign arready = (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_DATA);
  assign rlast   = rvalid && r_beat_last;
  assign rdata   = (rvalid && !r_oor_q) ? ram_rdata : 32'd0;
  assign rresp   = (rvalid && (r_oor_q || (r_size_q > 3'd2))) ? RESP_SLVERR : RESP_OKAY;
  assign rid     = r_id_q;

endmodule
